// File: rtl/clarvi_mem_pkg.sv
// clarvi_mem_pkg: shared types and constants for the CLARVI on-chip RAM arbiter
package clarvi_mem_pkg;

   typedef logic req_idx_t;

   localparam int RAM_ADDR_W       = 14;
   localparam int RAM_DATA_W       = 32;
   localparam int RAM_READ_LATENCY = 1;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

endpackage

// File: rtl/clarvi_rr_arb2.sv
// clarvi_rr_arb2: two-way combinational arbiter with a registered last-grant pointer
module clarvi_rr_arb2
   import clarvi_mem_pkg::*;
#(
   parameter arb_mode_e MODE = ARB_RR
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   output logic       grant,
   output logic       idx
);

   req_idx_t last;

   // pick the winner: a lone requester wins, contention goes to the one last does not name (or m0 in fixed mode)
   always_comb begin
      grant = |req;
      idx   = (req == 2'b11) ? ((MODE == ARB_FIXED) ? 1'b0 : ~last) : req[1];
   end

   // remember the most recent grant; reset to 1 so m0 wins the first contention
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last <= 1'b1;
      else if (grant)
         last <= idx;
   end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// clarvi_mem_arbiter: shares the single RAM port s1 between a fetch master (m0) and a data/DMA master (m1)
module clarvi_mem_arbiter
   import clarvi_mem_pkg::*;
#(
   parameter int ADDR_W   = RAM_ADDR_W,
   parameter int DATA_W   = RAM_DATA_W,
   parameter int ARB_MODE = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata
);

   logic     act0, act1, grant, g_read, g_write;
   req_idx_t idx, rd_owner;
   logic     rd_pend;

   assign act0      = m0_read | m0_write;
   assign act1      = m1_read | m1_write;
   assign ram_clken = 1'b1;

   clarvi_rr_arb2 #(
      .MODE (ARB_MODE == 1 ? ARB_FIXED : ARB_RR)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     ({act1, act0}),
      .grant   (grant),
      .idx     (idx)
   );

   // route the granted command to the RAM and hand back waitrequest / read returns
   always_comb begin
      g_read           = idx ? m1_read : m0_read;
      g_write          = idx ? m1_write : m0_write;
      ram_chipselect   = grant;
      ram_write        = grant & g_write;
      ram_address      = idx ? m1_address : m0_address;
      ram_byteenable   = idx ? m1_byteenable : m0_byteenable;
      ram_writedata    = idx ? m1_writedata : m0_writedata;
      m0_waitrequest   = act0 & ~(grant & ~idx);
      m1_waitrequest   = act1 & ~(grant & idx);
      m0_readdatavalid = rd_pend & ~rd_owner;
      m1_readdatavalid = rd_pend & rd_owner;
      m0_readdata      = ram_readdata;
      m1_readdata      = ram_readdata;
   end

   // track the single in-flight read; a read+write collision counts as a write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         rd_pend  <= grant & g_read & ~g_write;
         rd_owner <= idx;
      end
   end

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// tb_clarvi_mem_arbiter: checks round-robin and fixed-priority arbiters against a transaction-level model
module tb_clarvi_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ld;
   logic        r0, w0, r1, w1;
   logic [13:0] a0, a1;
   logic [3:0]  be0, be1;
   logic [31:0] wd0, wd1;

   logic [1:0]  wt0, wt1, rv0, rv1, cs, we, ck;
   logic [31:0] rd0 [2];
   logic [31:0] rd1 [2];
   logic [31:0] rwd [2];
   logic [31:0] rrd [2];
   logic [13:0] radr [2];
   logic [3:0]  rbe [2];
   logic [31:0] mem [2][16384];

   logic [31:0] smem [2][16384];
   bit          mlast [2];
   bit          ev [2];
   bit          eo [2];
   logic [31:0] ed [2];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   clarvi_mem_arbiter #(.ARB_MODE(0)) u0 (
      .clk(clk), .reset_n(reset_n),
      .m0_address(a0), .m0_byteenable(be0), .m0_read(r0), .m0_write(w0), .m0_writedata(wd0),
      .m0_waitrequest(wt0[0]), .m0_readdata(rd0[0]), .m0_readdatavalid(rv0[0]),
      .m1_address(a1), .m1_byteenable(be1), .m1_read(r1), .m1_write(w1), .m1_writedata(wd1),
      .m1_waitrequest(wt1[0]), .m1_readdata(rd1[0]), .m1_readdatavalid(rv1[0]),
      .ram_address(radr[0]), .ram_byteenable(rbe[0]), .ram_writedata(rwd[0]),
      .ram_chipselect(cs[0]), .ram_write(we[0]), .ram_clken(ck[0]), .ram_readdata(rrd[0]));

   clarvi_mem_arbiter #(.ARB_MODE(1)) u1 (
      .clk(clk), .reset_n(reset_n),
      .m0_address(a0), .m0_byteenable(be0), .m0_read(r0), .m0_write(w0), .m0_writedata(wd0),
      .m0_waitrequest(wt0[1]), .m0_readdata(rd0[1]), .m0_readdatavalid(rv0[1]),
      .m1_address(a1), .m1_byteenable(be1), .m1_read(r1), .m1_write(w1), .m1_writedata(wd1),
      .m1_waitrequest(wt1[1]), .m1_readdata(rd1[1]), .m1_readdatavalid(rv1[1]),
      .ram_address(radr[1]), .ram_byteenable(rbe[1]), .ram_writedata(rwd[1]),
      .ram_chipselect(cs[1]), .ram_write(we[1]), .ram_clken(ck[1]), .ram_readdata(rrd[1]));

   function automatic logic [31:0] init_word(int a);
      if (a == 16) return 32'hDEADBEEF;
      if (a == 16383) return 32'hAAAAAAAA;
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // RAM s1 stand-in: byte-enabled write, read data one cycle after the access
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ld) begin
            for (int a = 0; a < 16384; a++) mem[i][a] <= init_word(a);
         end else if (cs[i]) begin
            if (we[i]) begin
               for (int b = 0; b < 4; b++)
                  if (rbe[i][b]) mem[i][radr[i]][8*b +: 8] <= rwd[i][8*b +: 8];
            end
            rrd[i] <= mem[i][radr[i]];
         end
      end
   end

   always @(negedge clk)
      if (reset_n) assert (!(r0 && w0) && !(r1 && w1))
         else $error("FAIL illegal_cmd r0=%b w0=%b r1=%b w1=%b", r0, w0, r1, w1);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mlast[i] = 1'b1;
         ev[i]    = 1'b0;
      end
   endtask

   // one bus cycle: check at negedge against the model, advance the model at posedge
   task automatic cyc();
      bit any [2];
      bit g [2];
      bit act0, act1;
      @(negedge clk);
      act0 = r0 | w0;
      act1 = r1 | w1;
      for (int i = 0; i < 2; i++) begin
         string p = $sformatf("u%0d_", i);
         any[i] = act0 | act1;
         if (act0 && act1) g[i] = (i == 1) ? 1'b0 : !mlast[i];
         else g[i] = act1;
         chk({p, "m0_wait"}, 32'(wt0[i]), 32'(act0 && !(any[i] && !g[i])));
         chk({p, "m1_wait"}, 32'(wt1[i]), 32'(act1 && !(any[i] && g[i])));
         chk({p, "ram_cs"}, 32'(cs[i]), 32'(any[i]));
         chk({p, "ram_we"}, 32'(we[i]), 32'(any[i] && (g[i] ? w1 : w0)));
         if (any[i]) begin
            chk({p, "ram_addr"}, 32'(radr[i]), 32'(g[i] ? a1 : a0));
            chk({p, "ram_be"}, 32'(rbe[i]), 32'(g[i] ? be1 : be0));
            chk({p, "ram_wd"}, rwd[i], g[i] ? wd1 : wd0);
         end
         chk({p, "m0_rdv"}, 32'(rv0[i]), 32'(ev[i] && !eo[i]));
         chk({p, "m1_rdv"}, 32'(rv1[i]), 32'(ev[i] && eo[i]));
         if (ev[i]) begin
            chk({p, "m0_rdata"}, rd0[i], ed[i]);
            chk({p, "m1_rdata"}, rd1[i], ed[i]);
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         logic [13:0] ga;
         logic [3:0]  gb;
         logic [31:0] gd;
         bit          gr, gw;
         ga = g[i] ? a1 : a0;
         gb = g[i] ? be1 : be0;
         gd = g[i] ? wd1 : wd0;
         gr = g[i] ? r1 : r0;
         gw = g[i] ? w1 : w0;
         if (!reset_n || !any[i]) begin
            ev[i] = 1'b0;
         end else begin
            ev[i]    = gr && !gw;
            eo[i]    = g[i];
            ed[i]    = smem[i][ga];
            mlast[i] = g[i];
            if (gw)
               for (int b = 0; b < 4; b++)
                  if (gb[b]) smem[i][ga][8*b +: 8] = gd[8*b +: 8];
         end
      end
      #1;
   endtask

   task automatic idle();
      r0 = 0; w0 = 0; r1 = 0; w1 = 0;
   endtask

   initial begin
      bit sv0, sv1;
      reset_n = 1'b0;
      ld = 1'b1;
      idle();
      a0 = '0; a1 = '0; be0 = 4'hF; be1 = 4'hF; wd0 = '0; wd1 = '0;
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 16384; a++) smem[i][a] = init_word(a);
      model_reset();
      #1;
      chk("rst_rdv_u0", 32'({rv0[0], rv1[0]}), 32'd0);
      chk("rst_rdv_u1", 32'({rv0[1], rv1[1]}), 32'd0);
      cyc();
      ld = 1'b0;
      chk("rst_last_u0", 32'(u0.u_arb.last), 32'd1);
      chk("rst_last_u1", 32'(u1.u_arb.last), 32'd1);
      cyc();
      reset_n = 1'b1;
      cyc();

      r0 = 1; a0 = 14'h0010; be0 = 4'hF;
      cyc();
      idle();
      chk("single_m0_rdv", 32'(rv0[0]), 32'd1);
      chk("single_m0_rdata", rd0[0], 32'hDEADBEEF);
      chk("single_m1_rdv", 32'(rv1[0]), 32'd0);
      cyc();

      w1 = 1; a1 = 14'h3FFF; be1 = 4'b0011; wd1 = 32'h12345678;
      cyc();
      w1 = 0; r1 = 1; be1 = 4'hF;
      cyc();
      idle();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d_top_rdv", i), 32'(rv1[i]), 32'd1);
         chk($sformatf("u%0d_top_rdata", i), rd1[i], 32'hAAAA5678);
      end
      cyc();

      r1 = 1; a1 = 14'h0123;
      cyc();
      idle();
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_rdv_u0", 32'(rv1[0]), 32'd0);
      chk("midrst_rdv_u1", 32'(rv1[1]), 32'd0);
      cyc();
      reset_n = 1'b1;
      cyc();
      r0 = 1; r1 = 1; a0 = 14'h0010; a1 = 14'h3FFF;
      #1;
      chk("post_rst_m0_first", 32'(wt0[0]), 32'd0);
      for (int k = 0; k < 6; k++) begin
         a0 = 14'($urandom);
         a1 = 14'($urandom);
         cyc();
      end

      for (int k = 0; k < 8; k++) begin
         chk("fixed_m1_wait", 32'(wt1[1]), 32'd1);
         cyc();
      end
      r0 = 0;
      #1;
      chk("fixed_m1_granted", 32'(wt1[1]), 32'd0);
      cyc();
      idle();

      sv0 = mlast[0];
      sv1 = mlast[1];
      for (int k = 0; k < 5; k++) cyc();
      chk("idle_last_u0", 32'(u0.u_arb.last), 32'(sv0));
      chk("idle_last_u1", 32'(u1.u_arb.last), 32'(sv1));

      for (int k = 0; k < 400; k++) begin
         int c0, c1;
         c0 = $urandom_range(0, 2);
         c1 = $urandom_range(0, 2);
         r0 = (c0 == 1); w0 = (c0 == 2);
         r1 = (c1 == 1); w1 = (c1 == 2);
         a0 = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 15));
         a1 = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 15));
         be0 = 4'($urandom);
         be1 = 4'($urandom);
         wd0 = $urandom;
         wd1 = $urandom;
         cyc();
      end
      idle();
      cyc();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clarvi_mem_arbiter.md
# clarvi_mem_arbiter

Two-requester arbiter that shares the single-clock port s1 of the CLARVI SoC on-chip RAM (16384 × 32-bit words, byte-enabled, read data valid one cycle after the address is clocked) between an instruction-fetch master (m0) and a data/DMA master (m1). It converts the RAM's fixed-latency, always-ready slave into two pipelined Avalon-MM slaves with waitrequest and readdatavalid. It sits between the CPU/DMA fabric and the RAM inside the SoC.

## Interface
- ADDR_W, 14, word-address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, m0 wins
- clk  in  1  single clock for the block and the RAM port
- reset_n  in  1  asynchronous assert, active-low reset
- mN_address  in  ADDR_W  requester N word address (N = 0, 1)
- mN_byteenable  in  DATA_W/8  requester N byte lanes
- mN_read / mN_write  in  1  requester N command; both high together is illegal
- mN_writedata  in  DATA_W  requester N write data
- mN_waitrequest  out  1  command not accepted this cycle
- mN_readdata  out  DATA_W  read return data
- mN_readdatavalid  out  1  mN_readdata valid this cycle
- ram_address / ram_byteenable / ram_writedata  out  ADDR_W / DATA_W/8 / DATA_W  to RAM s1
- ram_chipselect, ram_write, ram_clken  out  1  to RAM s1; ram_clken tied 1
- ram_readdata  in  DATA_W  from RAM s1 (valid one cycle after the access)

## Operation
- Requester N is active when mN_read or mN_write is high.
- Arbitration is combinational each cycle, and exactly one requester is granted when any is active.
  - With a single active requester, that requester is granted.
  - With both active, ARB_MODE=0 grants the requester the pointer `last` does not name.
  - With both active, ARB_MODE=1 always grants m0.
- The granted requester sees waitrequest=0. The other active requester sees waitrequest=1 and must hold its command stable.
- An idle requester sees waitrequest=0 (Avalon-legal; it issues nothing).
- The grant is muxed straight to the RAM:
  - ram_chipselect = 1.
  - ram_write = granted mN_write.
  - ram_address, ram_byteenable and ram_writedata come from the granted requester.
- When nothing is active, ram_chipselect = 0 and ram_write = 0.
- Pointer `last` (1 bit, registered) is updated on every cycle with a grant, to the granted index. No grant leaves `last` unchanged.
- Read-return tracking uses registers rd_pend (1 bit) and rd_owner (1 bit). Each cycle they load (granted command is a read) and (granted index).
- In the cycle after an accepted read:
  - m[rd_owner]_readdatavalid = rd_pend.
  - Both mN_readdata = ram_readdata (unqualified broadcast).
- Writes produce no response.
- One read per cycle can be in flight. Back-to-back reads from alternating requesters return in issue order, one per cycle.
- Illegal read+write on one requester is treated as a write (read ignored). Verification flags it with an assertion.

## Timing
- Throughput is one RAM access per cycle with no bubbles. Read latency is 1 cycle from acceptance (the cycle with waitrequest=0) to readdatavalid.
- Under contention (ARB_MODE=0) the loser waits 1 cycle; with both requesters continuously active, grants alternate every cycle.
- Under ARB_MODE=1, m1 starves while m0 stays continuously active (documented and accepted).
- Reset assert (reset_n low, asynchronous):
  - last = 1, so m0 wins the first contention.
  - rd_pend = 0 and rd_owner = 0.
  - All readdatavalid outputs = 0 immediately.
- Combinational outputs follow the inputs during reset: ram_chipselect = 0 whenever no request is active. Sources must hold commands low during reset.
- Reset mid-read: the pending read is dropped, and no readdatavalid follows after reset deasserts.
- Reset deassertion must be synchronised externally to clk.

## Structure
- Package clarvi_mem_pkg:
  - typedef req_idx_t (1 bit).
  - localparams RAM_ADDR_W=14, RAM_DATA_W=32, RAM_READ_LATENCY=1.
  - enum arb_mode_e {ARB_RR, ARB_FIXED}.
- One natural sub-module: clarvi_rr_arb2. It holds the 2-way grant logic plus the `last` register and is reusable for the second RAM port.
- The top level holds the command mux and the read-return registers.

## Test plan
- Single requester: m0 reads addr 0x0010 (RAM holds 0xDEADBEEF) -> m0_waitrequest=0 that cycle; next cycle m0_readdatavalid=1 and m0_readdata=0xDEADBEEF; m1_readdatavalid=0.
- Contention, ARB_MODE=0, first cycle after reset: m0 and m1 both read continuously -> grants m0, m1, m0, m1; readdatavalid alternates one cycle later with the correct data per owner.
- Write then read, m1: write 0x12345678 with byteenable=4'b0011 to 0x3FFF (old value 0xAAAAAAAA), then read -> returns 0xAAAA5678; top address (wrap boundary) is handled.
- ARB_MODE=1: m0 and m1 both continuously active for 8 cycles -> m1_waitrequest=1 throughout; m1 is granted the cycle m0 drops.
- Reset mid-operation: m1 read accepted, reset_n pulled low before the next edge -> m1_readdatavalid stays 0; after release, a fresh contention grants m0 first.
- Idle: no requests for 5 cycles -> ram_chipselect=0 and ram_write=0, `last` is unchanged, no readdatavalid.
